mux_nx1_rr_pipe: RTL and testbench
==================================

Name: mux_nx1_rr_pipe

Overview:
- Parametrised N-way, WIDTH-bit channel multiplexer with one output register stage and valid/ready handshakes on every input channel and on the output.
- Successor to the plain 32-bit 2:1 datapath mux.
- Two modes:
  - MODE=0: the select input picks the source channel, as in the old mux.
  - MODE=1: a round-robin arbiter picks among the valid channels.
- Sits between multiple producers (register-file read ports, ALU result sources, memory return path) and a single downstream consumer.

Parameters:
- WIDTH, 32, data width in bits of each channel and of the output.
- NCH, 4, number of input channels; legal range 2..16. SELW = max(1, clog2(NCH)) is a derived localparam.
- MODE, 0, 0 = external select, 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  channel i has a beat available.
- in_ready  output  NCH  channel i beat accepted this cycle when in_valid[i] && in_ready[i].
- sel  input  SELW  source channel in MODE=0; ignored in MODE=1.
- out_data  output  WIDTH  registered output beat.
- out_valid  output  1  out_data holds an undelivered beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_ch  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset: asynchronous on reset=1.
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is all-zero while reset is asserted.
  - A beat held when reset asserts is discarded, never delivered.
- load_en = !out_valid || out_ready (combinational). The register can take a new beat when empty or draining this cycle.
- Grant (combinational, at most one bit set, gnt_vld flags a grant):
  - MODE=0: grant channel sel iff sel < NCH and in_valid[sel]=1; otherwise no grant. Valids on other channels are ignored.
  - MODE=1: grant the first channel with in_valid=1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (mod NCH). No grant if in_valid is all zero.
- in_ready[i] = load_en && gnt_vld && (granted index == i). in_ready never depends on out_data.
- Transfer in: on a clk edge with load_en && gnt_vld, the register loads.
  - out_data <= granted channel data, out_ch <= granted index, out_valid <= 1.
  - Latency: 1 cycle from input acceptance to out_valid.
- Transfer out: on a clk edge with out_valid && out_ready and no new grant, out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one and out_valid stays 1. Sustained throughput is 1 beat/cycle with no bubble.
- Stall: while out_valid && !out_ready, out_data, out_ch and out_valid hold stable and all in_ready=0.
- Round-robin pointer (MODE=1 only): updates only on an accepted input transfer, to ptr <= (granted index + 1) mod NCH.
  - Wraps NCH-1 -> 0.
  - Unchanged on cycles with no transfer, including stall cycles.
  - In MODE=0 ptr stays 0.
- Fairness (MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,... A continuously valid channel waits at most NCH-1 transfers.
- Non-power-of-2 NCH: indices >= NCH are never granted and sel >= NCH produces no grant.
- Implementation: synthesizable; no latches; pure combinational grant path; a single always block on posedge clk or posedge reset.

Test Plan:
- Reset/idle: assert reset mid-beat (out_valid=1, out_data=0xDEADBEEF) -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately, without waiting for a clock edge. After release with no in_valid, out_valid stays 0.
- MODE=0 select: NCH=4, in_valid=4'b1111, channel data 0x11111111*i, sel=2, out_ready=1 -> next cycle out_data=0x22222222, out_ch=2, in_ready=4'b0100. With sel=3 and in_valid[3]=0 -> no grant, in_ready=0, out_valid drops after the drain.
- MODE=1 round-robin: NCH=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
- MODE=1 sparse/wrap: in_valid=4'b1001 continuously, ptr=0 -> grants alternate 0,3,0,3. Then in_valid=4'b0100 with ptr=1 -> grant 2, ptr becomes 3.
- Backpressure: out_valid=1, out_data=0xA5A5A5A5, out_ready=0 for 5 cycles with new inputs valid -> out_data/out_ch unchanged, in_ready=0, ptr unchanged. Then raise out_ready -> the next beat loads in the same cycle with no bubble.
- Parameter sweep: NCH=3, WIDTH=8, MODE=1, all valid -> out_ch sequence 0,1,2,0. With MODE=0, sel=3 -> never granted.

Source files
------------

// File: rtl/mux_nx1_rr_pipe.sv
// N-way channel multiplexer with a single output register stage.
// Every input channel and the output use a valid/ready handshake.
// The source channel is chosen by the external select (MODE=0) or by a
// round-robin arbiter over the valid channels (MODE=1).
module mux_nx1_rr_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  ptr;
  logic [2*NCH-1:0] rot;
  logic [SELW-1:0]  rr_off;
  logic [SELW:0]    rr_sum;

  // The output register can take a beat when it is empty or draining now.
  assign load_en = !out_valid || out_ready;

  // Pick at most one channel to grant. Round-robin rotates the valid mask so
  // the pointer channel sits at bit 0, takes the lowest set bit, then maps
  // that offset back to an absolute channel index modulo NCH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rot     = '0;
    rr_off  = '0;
    rr_sum  = '0;
    if (MODE == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      rot = {in_valid, in_valid} >> ptr;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (rot[k]) begin
          gnt_vld = 1'b1;
          rr_off  = SELW'(k);
        end
      end
      rr_sum = {1'b0, ptr} + {1'b0, rr_off};
      if (rr_sum >= (SELW + 1)'(NCH)) begin
        rr_sum = rr_sum - (SELW + 1)'(NCH);
      end
      gnt_idx = rr_sum[SELW-1:0];
    end
  end

  // Route the granted channel's data and raise its ready only when the
  // register will actually capture it this cycle.
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
      in_ready[i] = !reset && load_en && gnt_vld && (gnt_idx == SELW'(i));
    end
  end

  // Output register and round-robin pointer; a new beat may replace one
  // that is draining in the same cycle, so back-to-back beats need no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (load_en && gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        if (MODE == 1) begin
          ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr_pipe.sv
// Self-checking bench for mux_nx1_rr_pipe: four instances (select and
// round-robin, four and three channels) share clock and reset and are
// compared every cycle against a queue-free behavioural model, plus
// directed scenarios with literal expectations.
module tb_mux_nx1_rr_pipe;

  localparam int NCHS  [4] = '{4, 4, 3, 3};
  localparam int MODES [4] = '{0, 1, 1, 0};
  localparam logic [31:0] MASKS [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000FF, 32'h000000FF};

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [31:0] id   [4][4];
  logic [3:0]  iv   [4];
  logic [1:0]  sl   [4];
  logic        ordy [4];

  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2, ir3;
  logic [31:0] od0, od1;
  logic [7:0]  od2, od3;
  logic        ov0, ov1, ov2, ov3;
  logic [1:0]  oc0, oc1, oc2, oc3;

  logic [31:0] dut_data [4];
  logic        dut_valid [4];
  logic [1:0]  dut_ch [4];
  logic [3:0]  dut_rdy [4];

  int checks = 0;
  int failures = 0;

  logic        m_valid [4];
  logic [31:0] m_data [4];
  int          m_ch [4];
  int          m_ptr [4];

  always #5 clk = ~clk;

  mux_nx1_rr_pipe #(.WIDTH(32), .NCH(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset),
    .in_data({id[0][3], id[0][2], id[0][1], id[0][0]}), .in_valid(iv[0]), .in_ready(ir0),
    .sel(sl[0]), .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]), .out_ch(oc0));

  mux_nx1_rr_pipe #(.WIDTH(32), .NCH(4), .MODE(1)) u1 (
    .clk(clk), .reset(reset),
    .in_data({id[1][3], id[1][2], id[1][1], id[1][0]}), .in_valid(iv[1]), .in_ready(ir1),
    .sel(sl[1]), .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]), .out_ch(oc1));

  mux_nx1_rr_pipe #(.WIDTH(8), .NCH(3), .MODE(1)) u2 (
    .clk(clk), .reset(reset),
    .in_data({id[2][2][7:0], id[2][1][7:0], id[2][0][7:0]}), .in_valid(iv[2][2:0]), .in_ready(ir2),
    .sel(sl[2]), .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]), .out_ch(oc2));

  mux_nx1_rr_pipe #(.WIDTH(8), .NCH(3), .MODE(0)) u3 (
    .clk(clk), .reset(reset),
    .in_data({id[3][2][7:0], id[3][1][7:0], id[3][0][7:0]}), .in_valid(iv[3][2:0]), .in_ready(ir3),
    .sel(sl[3]), .out_data(od3), .out_valid(ov3), .out_ready(ordy[3]), .out_ch(oc3));

  // Gather the four instances' outputs into indexable arrays.
  always_comb begin
    dut_data[0] = od0;  dut_data[1] = od1;
    dut_data[2] = {24'h0, od2};  dut_data[3] = {24'h0, od3};
    dut_valid[0] = ov0; dut_valid[1] = ov1; dut_valid[2] = ov2; dut_valid[3] = ov3;
    dut_ch[0] = oc0; dut_ch[1] = oc1; dut_ch[2] = oc2; dut_ch[3] = oc3;
    dut_rdy[0] = ir0; dut_rdy[1] = ir1;
    dut_rdy[2] = {1'b0, ir2}; dut_rdy[3] = {1'b0, ir3};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: on each falling edge compare the DUTs to the modelled state,
  // then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (reset) begin
        m_valid[u] = 1'b0; m_data[u] = '0; m_ch[u] = 0; m_ptr[u] = 0;
        checkOutput($sformatf("rst_valid%0d", u), {31'h0, dut_valid[u]}, 32'h0);
        checkOutput($sformatf("rst_data%0d", u), dut_data[u], 32'h0);
        checkOutput($sformatf("rst_ch%0d", u), {30'h0, dut_ch[u]}, 32'h0);
        checkOutput($sformatf("rst_rdy%0d", u), {28'h0, dut_rdy[u]}, 32'h0);
      end else begin
        bit g;
        int gi;
        bit load;
        logic [3:0] exp_rdy;
        g = 0; gi = 0;
        if (MODES[u] == 0) begin
          if (int'(sl[u]) < NCHS[u] && iv[u][sl[u]]) begin
            g = 1; gi = int'(sl[u]);
          end
        end else begin
          for (int k = 0; k < NCHS[u]; k++) begin
            int c;
            c = (m_ptr[u] + k) % NCHS[u];
            if (!g && iv[u][c]) begin
              g = 1; gi = c;
            end
          end
        end
        load = !m_valid[u] || ordy[u];
        exp_rdy = (load && g) ? 4'(1 << gi) : 4'h0;
        checkOutput($sformatf("rdy%0d", u), {28'h0, dut_rdy[u]}, {28'h0, exp_rdy});
        checkOutput($sformatf("valid%0d", u), {31'h0, dut_valid[u]}, {31'h0, m_valid[u]});
        checkOutput($sformatf("data%0d", u), dut_data[u], m_data[u]);
        checkOutput($sformatf("ch%0d", u), {30'h0, dut_ch[u]}, 32'(m_ch[u]));
        if (load && g) begin
          m_valid[u] = 1'b1;
          m_data[u]  = id[u][gi] & MASKS[u];
          m_ch[u]    = gi;
          if (MODES[u] == 1) m_ptr[u] = (gi + 1) % NCHS[u];
        end else if (m_valid[u] && ordy[u]) begin
          m_valid[u] = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input logic r);
    for (int u = 0; u < 4; u++) begin
      iv[u] = v;
      ordy[u] = r;
    end
  endtask

  initial begin
    int rr_exp3 [4];
    rr_exp3 = '{0, 1, 2, 0};
    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < 4; i++) id[u][i] = 32'h11111111 * i;
      iv[u] = '0; sl[u] = '0; ordy[u] = 1'b0;
    end

    // Reset, then idle with no valid input.
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("idle_valid0", {31'h0, ov0}, 32'h0);
    checkOutput("idle_valid1", {31'h0, ov1}, 32'h0);

    // Select mode picks channel 2; round-robin instances cycle through all.
    applyStimulus(4'hF, 1'b1);
    sl[0] = 2'd2; sl[3] = 2'd2;
    #1;
    checkOutput("sel2_rdy", {28'h0, ir0}, 32'h4);
    for (int j = 0; j < 8; j++) begin
      tick();
      checkOutput("rr4_ch", {30'h0, oc1}, 32'(j % 4));
      checkOutput("rr4_valid", {31'h0, ov1}, 32'h1);
      if (j < 4) checkOutput("rr3_ch", {30'h0, oc2}, 32'(rr_exp3[j]));
      if (j == 0) begin
        checkOutput("sel2_data", od0, 32'h22222222);
        checkOutput("sel2_ch", {30'h0, oc0}, 32'h2);
      end
    end

    // Select an invalid channel, and an out-of-range one on the 3-way mux.
    sl[0] = 2'd3; iv[0] = 4'b0111; sl[3] = 2'd3;
    #1;
    checkOutput("sel3_rdy", {28'h0, ir0}, 32'h0);
    checkOutput("seloor_rdy", {29'h0, ir3}, 32'h0);
    tick();
    checkOutput("sel3_drain", {31'h0, ov0}, 32'h0);
    checkOutput("seloor_valid", {31'h0, ov3}, 32'h0);

    // Backpressure: load A5A5A5A5, then stall five cycles.
    applyStimulus(4'hF, 1'b0);
    for (int u = 0; u < 4; u++) id[u][1] = 32'hA5A5A5A5;
    sl[0] = 2'd1;
    tick();
    checkOutput("bp_load", od0, 32'hA5A5A5A5);
    for (int j = 0; j < 5; j++) begin
      tick();
      checkOutput("bp_data", od0, 32'hA5A5A5A5);
      checkOutput("bp_ch", {30'h0, oc0}, 32'h1);
      checkOutput("bp_valid", {31'h0, ov0}, 32'h1);
      checkOutput("bp_rdy", {28'h0, ir0}, 32'h0);
      checkOutput("bp_rdy_rr", {28'h0, ir1}, 32'h0);
    end
    applyStimulus(4'hF, 1'b1);
    sl[0] = 2'd2;
    #1;
    checkOutput("bp_release_rdy", {28'h0, ir0}, 32'h4);
    tick();
    checkOutput("bp_next_data", od0, 32'h22222222);
    checkOutput("bp_next_valid", {31'h0, ov0}, 32'h1);

    // Reset asserted mid-beat clears everything immediately.
    sl[0] = 2'd0; id[0][0] = 32'hDEADBEEF;
    tick();
    ordy[0] = 1'b0;
    checkOutput("rst_pre_data", od0, 32'hDEADBEEF);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", {31'h0, ov0}, 32'h0);
    checkOutput("rst_async_data", od0, 32'h0);
    checkOutput("rst_async_ch", {30'h0, oc0}, 32'h0);
    checkOutput("rst_async_rdy", {28'h0, ir0}, 32'h0);
    checkOutput("rst_async_rdy_rr", {28'h0, ir1}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(4'h0, 1'b1);
    tick();
    checkOutput("post_rst_idle", {31'h0, ov0}, 32'h0);

    // Sparse round-robin with wrap, then a lone channel from ptr=1.
    applyStimulus(4'b1001, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("sparse_ch", {30'h0, oc1}, (k % 2 == 1) ? 32'h0 : 32'h3);
    end
    iv[1] = 4'b0100;
    tick();
    checkOutput("lone_ch", {30'h0, oc1}, 32'h2);
    iv[1] = 4'b1001;
    tick();
    checkOutput("ptr_after_lone", {30'h0, oc1}, 32'h3);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int u = 0; u < 4; u++) begin
        iv[u] = 4'($urandom);
        sl[u] = 2'($urandom);
        ordy[u] = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < 4; i++) id[u][i] = $urandom;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
